// File: rtl/psum_readout_ctrl.sv
// psum_readout_ctrl: streams a burst of len_onij PSUM words onto the readout port.
// A one-cycle start in IDLE launches the burst. The SRAM read for word 0 is issued in
// the start cycle itself, so each word appears one cycle after its address, with no gaps.
module psum_readout_ctrl #(
   parameter int psum_bw  = 16,
   parameter int col      = 8,
   parameter int len_onij = 16,
   parameter int addr_w   = 11
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     readout_start,
   input  logic [addr_w-1:0]        base_addr,
   output logic                     CEN_pmem,
   output logic                     WEN_pmem,
   output logic [addr_w-1:0]        A_pmem,
   input  logic [psum_bw*col-1:0]   Q_pmem,
   output logic [psum_bw*col-1:0]   readout,
   output logic                     readout_valid,
   output logic                     busy,
   output logic                     done
);

   localparam int CW = $clog2(len_onij) + 1;
   localparam int DW = psum_bw * col;
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_LAST = CW'(len_onij - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_LAST = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       c_q, c_d;
   logic [addr_w-1:0]   base_q, base_d;
   logic [DW-1:0]       readout_q, readout_d;
   logic                valid_q, valid_d;
   logic                done_q, done_d;
   logic                cen_s;
   logic [addr_w-1:0]   addr_s;

   // State and datapath registers; reset abandons any burst in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         c_q       <= '0;
         base_q    <= '0;
         readout_q <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         c_q       <= c_d;
         base_q    <= base_d;
         readout_q <= readout_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
      end
   end

   // Next-state, SRAM address/enable and output-register updates.
   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      base_d    = base_q;
      readout_d = readout_q;
      valid_d   = valid_q;
      done_d    = done_q;
      cen_s     = 1'b1;
      addr_s    = base_addr;
      case (state_q)
         S_IDLE: begin
            // Word 0 is fetched in the start cycle straight from base_addr.
            cen_s   = ~readout_start;
            addr_s  = base_addr;
            valid_d = 1'b0;
            done_d  = 1'b0;
            if (readout_start) begin
               base_d  = base_addr;
               c_d     = C_ONE;
               state_d = (len_onij > 1) ? S_READ : S_LAST;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            // Address arithmetic wraps naturally at addr_w bits.
            cen_s     = 1'b0;
            addr_s    = base_q + addr_w'(c_q);
            readout_d = Q_pmem;
            valid_d   = 1'b1;
            done_d    = 1'b0;
            if (c_q == C_LAST) begin
               state_d = S_LAST;
            end else begin
               c_d     = c_q + C_ONE;
               state_d = S_READ;
            end
         end
         S_LAST: begin
            // All reads issued; capture the final word and flag completion.
            cen_s     = 1'b1;
            addr_s    = base_q;
            readout_d = Q_pmem;
            valid_d   = 1'b1;
            done_d    = 1'b1;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign CEN_pmem      = cen_s;
   assign WEN_pmem      = 1'b1;
   assign A_pmem        = addr_s;
   assign readout       = readout_q;
   assign readout_valid = valid_q;
   assign done          = done_q;
   assign busy          = (state_q != S_IDLE);

endmodule

// File: doc/psum_readout_ctrl.md
# psum_readout_ctrl

Read-side responder of the core's output readout interface. After a one-cycle `readout_start` pulse, the block streams `len_onij` output-feature-map words from PSUM memory onto `readout`, one word per clock, with fixed latency. It sits inside `core` between the PSUM SRAM read port and the top-level `readout` port. The bench or host samples `readout` without any back-pressure.

## Interface
- `psum_bw`, 16: bits per output channel.
- `col`, 8: channels per word; word width is `psum_bw*col`.
- `len_onij`, 16: words per readout burst; must be ≥1.
- `addr_w`, 11: PSUM memory address width.

- `clk`  in  1  — clock; all state updates on the rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `readout_start`  in  1  — one-cycle request pulse, sampled on a rising edge.
- `base_addr`  in  addr_w  — PSUM address of word 0; sampled together with an accepted start.
- `CEN_pmem`  out  1  — PSUM chip enable, active-low.
- `WEN_pmem`  out  1  — PSUM write enable, active-low; tied to 1 because this block only reads.
- `A_pmem`  out  addr_w  — PSUM read address.
- `Q_pmem`  in  psum_bw*col  — PSUM read data; synchronous SRAM, valid in the cycle after the address edge.
- `readout`  out  psum_bw*col  — registered output word.
- `readout_valid`  out  1  — high while `readout` carries a word of the current burst.
- `busy`  out  1  — high when state ≠ IDLE.
- `done`  out  1  — one-cycle pulse, coincident with the last word.

## Operation
- FSM states: IDLE, READ, LAST.
  - Counter `c` is `$clog2(len_onij)+1` bits.
  - Register `base_r` is `addr_w` bits.
- **IDLE**
  - `CEN_pmem = ~readout_start` (combinational).
  - `A_pmem = base_addr`.
  - On an edge with `readout_start=1`: `base_r<=base_addr`, `c<=1`. Next state is READ if `len_onij>1`, else LAST.
  - On every IDLE edge: `readout_valid<=0`, `done<=0`.
- **READ**
  - `CEN_pmem=0`, `A_pmem=base_r+c`, computed modulo 2^addr_w (address wraps).
  - Each edge: `readout<=Q_pmem`, `readout_valid<=1`.
  - If `c==len_onij-1`, go to LAST; else `c<=c+1`.
- **LAST**
  - `CEN_pmem=1`.
  - Edge: `readout<=Q_pmem`, `readout_valid<=1`, `done<=1`, go to IDLE.
- `readout_start` outside IDLE is ignored: no restart, no queueing.
- `readout` holds its last word after the burst and is not cleared in IDLE.
- `base_addr` changes after acceptance have no effect on the burst.
- Reset (asynchronous, `reset=0`): state=IDLE, `c=0`, `base_r=0`, `readout=0`, `readout_valid=0`, `done=0`.
  - A reset during a burst abandons it; no further reads are issued after reset asserts.
- No arithmetic on data; words pass through bit-exact.

## Timing
- Let edge E1 be the rising edge where `readout_start=1` is sampled in IDLE.
  - Address `base` is read at E1.
  - Word i is presented from edge E(2+i) to E(3+i), for i = 0..len_onij-1.
  - Sample at the falling edge inside that window.
- Latency from the start edge to word 0 is 1 cycle. Throughput is 1 word per cycle, gapless.
- `done=1` and `readout_valid=1` are both high during the last word's window, E(len_onij+1)→E(len_onij+2).
- `busy` is high from E1 to E(len_onij+1); it is low again during the last word's window.
- Back-to-back bursts:
  - A start during the last word's window (block is in IDLE) is accepted.
  - `readout_valid` drops for exactly one cycle before the new word 0.
- PSUM reads issued per burst: exactly `len_onij`. `CEN_pmem` is low for exactly `len_onij` consecutive cycles.

## Test plan
- **Basic burst.** Preload PSUM so that addr k holds `{8{k[15:0]}}`. Pulse start with base=0.
  - Word i appears at E(2+i) for i=0..15; `valid` high for 16 cycles.
  - `done` high only during word 15; `CEN_pmem` low for 16 cycles.
- **Start while busy.** Pulse start again at E5.
  - The burst is unchanged; no extra reads; `done` pulses once.
- **Mid-burst reset.** Assert `reset=0` between E6 and E7.
  - `readout=0` and `valid=0` immediately (asynchronous).
  - `CEN_pmem=1` after reset; state is IDLE.
  - A new start after reset release yields the full 16 words.
- **Address wrap.** base=2040 with addr_w=11.
  - Addresses read are 2040..2047, then 0..7; data follows that order.
- **Back-to-back.** Pulse a second start during word 15's window.
  - One cycle with `valid=0`, then word 0 of the new burst.
- **Single-word build.** len_onij=1.
  - Start at E1 → one word at E2 with `done=1`; `CEN_pmem` low for one cycle only.
